// File: rtl/irq_sequencer.sv
// irq_sequencer: synchronizes device flags into irqRq, tracks ION with one-instruction delay, and runs interrupt entry (save PC at VECTOR-1, jump to VECTOR)
//   in : CLK, RESETn (sync, active-low), dev_flag[8], dev_mask[8], ion_set, ion_clr, insn_end, pc[12], mem_ack
//   out: irqRq, ion, mem_req, mem_addr[12], mem_wdata[12], pc_load, pc_new[12], busy, irq_taken
module irq_sequencer #(
  parameter logic [11:0] VECTOR = 12'o0001
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [7:0]  dev_flag,
  input  logic [7:0]  dev_mask,
  input  logic        ion_set,
  input  logic        ion_clr,
  input  logic        insn_end,
  input  logic [11:0] pc,
  input  logic        mem_ack,
  output logic        irqRq,
  output logic        ion,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  output logic [11:0] mem_wdata,
  output logic        pc_load,
  output logic [11:0] pc_new,
  output logic        busy,
  output logic        irq_taken
);
  typedef enum logic [1:0] {IDLE, SAVE, VEC, DONE} state_t;
  state_t state, state_n;
  logic [7:0] sync1, sync2;
  logic ion_pend;
  logic [11:0] save_pc;
  logic entry;
  // ion is registered, so an insn_end that promotes ion_pend cannot also start entry
  assign entry = state == IDLE && insn_end && ion && irqRq;
  always_ff @(posedge CLK)
    if (!RESETn) begin
      sync1 <= '0;
      sync2 <= '0;
      irqRq <= 1'b0;
      ion <= 1'b0;
      ion_pend <= 1'b0;
      save_pc <= '0;
      state <= IDLE;
    end else begin
      sync1 <= dev_flag;
      sync2 <= sync1;
      irqRq <= |(sync2 & dev_mask);
      state <= state_n;
      if (entry) save_pc <= pc;
      if (ion_clr) begin
        ion <= 1'b0;
        ion_pend <= 1'b0;
      end else if (entry) begin
        ion <= 1'b0;
        ion_pend <= ion_set;
      end else begin
        ion <= ion | (insn_end & ion_pend);
        ion_pend <= ion_set | (ion_pend & ~insn_end);
      end
    end
  always_comb begin
    state_n = entry ? SAVE : state == SAVE ? (mem_ack ? VEC : SAVE) : state == VEC ? DONE : IDLE;
    mem_req = state == SAVE;
    mem_addr = mem_req ? VECTOR - 12'd1 : '0;
    mem_wdata = mem_req ? save_pc : '0;
    pc_load = state == VEC;
    pc_new = pc_load ? VECTOR : '0;
    busy = state != IDLE;
    irq_taken = state == DONE;
  end
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed scoreboard bench for irq_sequencer, default VECTOR and VECTOR=0 instances side by side
module tb_irq_sequencer;
  logic CLK = 1'b0;
  logic RESETn;
  logic [7:0] dev_flag, dev_mask;
  logic ion_set, ion_clr, insn_end, mem_ack;
  logic [11:0] pc;
  logic irq0, ion0, mreq0, pld0, busy0, tk0;
  logic [11:0] maddr0, mwd0, pnew0;
  logic irq1, ion1, mreq1, pld1, busy1, tk1;
  logic [11:0] maddr1, mwd1, pnew1;
  int passed = 0;
  int total = 0;
  typedef struct {
    string tag;
    logic [41:0] e0;
    logic [41:0] e1;
  } exp_t;
  exp_t q[$];

  always #5 CLK = ~CLK;

  irq_sequencer u0 (
    .CLK(CLK), .RESETn(RESETn), .dev_flag(dev_flag), .dev_mask(dev_mask),
    .ion_set(ion_set), .ion_clr(ion_clr), .insn_end(insn_end), .pc(pc), .mem_ack(mem_ack),
    .irqRq(irq0), .ion(ion0), .mem_req(mreq0), .mem_addr(maddr0), .mem_wdata(mwd0),
    .pc_load(pld0), .pc_new(pnew0), .busy(busy0), .irq_taken(tk0)
  );

  irq_sequencer #(.VECTOR(12'o0000)) u1 (
    .CLK(CLK), .RESETn(RESETn), .dev_flag(dev_flag), .dev_mask(dev_mask),
    .ion_set(ion_set), .ion_clr(ion_clr), .insn_end(insn_end), .pc(pc), .mem_ack(mem_ack),
    .irqRq(irq1), .ion(ion1), .mem_req(mreq1), .mem_addr(maddr1), .mem_wdata(mwd1),
    .pc_load(pld1), .pc_new(pnew1), .busy(busy1), .irq_taken(tk1)
  );

  // expected output vector; st: 0 IDLE, 1 SAVE, 2 VEC, 3 DONE
  function automatic logic [41:0] ex(input bit irq, input bit io, input int st, input logic [11:0] wd, input logic [11:0] v);
    logic [11:0] a, w, n;
    a = (st == 1) ? v - 12'd1 : 12'h000;
    w = (st == 1) ? wd : 12'h000;
    n = (st == 2) ? v : 12'h000;
    return {irq, io, st == 1, a, w, st == 2, n, st != 0, st == 3};
  endfunction

  task automatic chk(input string tag, input bit irq, input bit io, input int st, input logic [11:0] wd);
    exp_t e;
    logic [41:0] o0, o1;
    q.push_back('{tag, ex(irq, io, st, wd, 12'o0001), ex(irq, io, st, wd, 12'o0000)});
    @(posedge CLK);
    #1;
    e = q.pop_front();
    o0 = {irq0, ion0, mreq0, maddr0, mwd0, pld0, pnew0, busy0, tk0};
    o1 = {irq1, ion1, mreq1, maddr1, mwd1, pld1, pnew1, busy1, tk1};
    total++;
    assert (o0 === e.e0) passed++;
    else $error("FAIL %s vec1 observed=%h expected=%h", e.tag, o0, e.e0);
    total++;
    assert (o1 === e.e1) passed++;
    else $error("FAIL %s vec0 observed=%h expected=%h", e.tag, o1, e.e1);
  endtask

  initial begin
    RESETn = 1'b0;
    dev_flag = 8'h01;
    dev_mask = 8'h01;
    ion_set = 1'b0;
    ion_clr = 1'b0;
    insn_end = 1'b0;
    mem_ack = 1'b0;
    pc = 12'o4567;
    chk("reset_a", 0, 0, 0, 0);
    chk("reset_b", 0, 0, 0, 0);
    RESETn = 1'b1;
    chk("sync_1", 0, 0, 0, 0);
    chk("sync_2", 0, 0, 0, 0);
    chk("sync_3", 1, 0, 0, 0);
    dev_mask = 8'h00;
    chk("mask_off", 0, 0, 0, 0);
    dev_mask = 8'h01;
    chk("mask_on", 1, 0, 0, 0);
    ion_set = 1'b1;
    chk("ion_pend", 1, 0, 0, 0);
    ion_set = 1'b0;
    insn_end = 1'b1;
    chk("ion_rise", 1, 1, 0, 0);
    chk("entry", 1, 0, 1, 12'o4567);
    insn_end = 1'b0;
    pc = 12'o1234;
    dev_flag = 8'h00;
    chk("save_2", 1, 0, 1, 12'o4567);
    chk("save_3", 1, 0, 1, 12'o4567);
    chk("save_4", 0, 0, 1, 12'o4567);
    mem_ack = 1'b1;
    chk("vec", 0, 0, 2, 0);
    mem_ack = 1'b0;
    chk("done", 0, 0, 3, 0);
    chk("idle", 0, 0, 0, 0);
    mem_ack = 1'b1;
    chk("ack_idle", 0, 0, 0, 0);
    mem_ack = 1'b0;
    dev_flag = 8'h80;
    dev_mask = 8'h80;
    chk("resync_1", 0, 0, 0, 0);
    chk("resync_2", 0, 0, 0, 0);
    chk("resync_3", 1, 0, 0, 0);
    ion_set = 1'b1;
    ion_clr = 1'b1;
    chk("set_clr", 1, 0, 0, 0);
    ion_set = 1'b0;
    ion_clr = 1'b0;
    insn_end = 1'b1;
    chk("no_entry", 1, 0, 0, 0);
    insn_end = 1'b0;
    ion_set = 1'b1;
    chk("arm_2", 1, 0, 0, 0);
    ion_set = 1'b0;
    insn_end = 1'b1;
    chk("rise_2", 1, 1, 0, 0);
    mem_ack = 1'b1;
    chk("entry_2", 1, 0, 1, 12'o1234);
    insn_end = 1'b0;
    chk("vec_2", 1, 0, 2, 0);
    mem_ack = 1'b0;
    chk("done_2", 1, 0, 3, 0);
    chk("idle_2", 1, 0, 0, 0);
    pc = 12'o7777;
    ion_set = 1'b1;
    chk("arm_3", 1, 0, 0, 0);
    ion_set = 1'b0;
    insn_end = 1'b1;
    chk("rise_3", 1, 1, 0, 0);
    chk("entry_3", 1, 0, 1, 12'o7777);
    insn_end = 1'b0;
    RESETn = 1'b0;
    chk("rst_save", 0, 0, 0, 0);
    RESETn = 1'b1;
    mem_ack = 1'b1;
    chk("ack_drop", 0, 0, 0, 0);
    mem_ack = 1'b0;
    chk("post_1", 0, 0, 0, 0);
    chk("post_2", 1, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/irq_sequencer.md
IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 SHALL have ports, clock and reset first: CLK in 1 system clock; RESETn in 1 reset, synchronous, active-low.
REQ-002 SHALL have: dev_flag in 8 asynchronous device interrupt flags, level; dev_mask in 8 per-device enable; ion_set in 1 ION decoded, one-cycle pulse; ion_clr in 1 IOF/CAF/SKON-taken, one-cycle pulse.
REQ-003 SHALL have: insn_end in 1 CPU at instruction boundary, one-cycle pulse; pc in 12 current PC; mem_ack in 1 memory write accepted.
REQ-004 SHALL have outputs: irqRq 1 synchronized request; ion 1 interrupts enabled; mem_req 1; mem_addr 12; mem_wdata 12; pc_load 1; pc_new 12; busy 1 CPU-stall; irq_taken 1 pulse.
REQ-005 SHALL have parameter VECTOR, default 12'o0001, PC loaded on interrupt entry; save address is VECTOR-1.

Function
REQ-006 SHALL pass each dev_flag bit through its own two-flop synchronizer; irqRq = |(sync_flag & dev_mask), registered, 3 cycles flag-to-irqRq.
REQ-007 SHALL arm ion_pend on ion_set; ion SHALL rise on the first insn_end after the cycle ion_pend was set (ION delayed by one instruction).
REQ-008 SHALL clear ion and ion_pend on ion_clr; ion_clr SHALL win over ion_set in the same cycle.
REQ-009 SHALL implement FSM IDLE, SAVE, VEC, DONE; state encoding free.
REQ-010 IDLE -> SAVE SHALL occur when insn_end & ion & irqRq; in that cycle ion and ion_pend clear and PC is latched to an internal 12-bit save register.
REQ-011 An insn_end that also promotes ion_pend SHALL NOT start entry; earliest entry is the next insn_end.
REQ-012 SAVE: mem_req=1, mem_addr=VECTOR-1 (12-bit wrap), mem_wdata=saved PC (wrapping); hold all three stable until mem_ack; mem_ack SHALL move to VEC.
REQ-013 VEC: pc_load=1, pc_new=VECTOR for exactly one cycle -> DONE.
REQ-014 DONE: irq_taken=1 for one cycle -> IDLE.
REQ-015 busy SHALL be 1 in SAVE, VEC and DONE, 0 in IDLE.
REQ-016 mem_ack outside SAVE SHALL be ignored; a mem_ack in the SAVE entry cycle SHALL be honoured (min entry 3 cycles).
REQ-017 ion_set/ion_clr during SAVE/VEC/DONE SHALL update ion_pend/ion normally; no nested entry until IDLE.
REQ-018 Flags deasserting after entry SHALL NOT abort the sequence.
REQ-019 Outputs not named active in a state SHALL be 0 (mem_addr, mem_wdata, pc_new 0 except as stated).

Reset
REQ-020 RESETn=0 at a CLK edge SHALL force IDLE, clear synchronizers, ion, ion_pend, save register, and all outputs to 0, including mid-sequence; mem_ack pending is dropped.
REQ-021 First cycle after RESETn rises: no entry possible, irqRq=0 until flags propagate per REQ-006.

Verification
REQ-022 dev_flag=8'h01, dev_mask=8'h01 from reset -> irqRq=1 on 3rd edge; mask=0 -> irqRq=0 after one edge.
REQ-023 ion_set, then insn_end -> ion=1 after that insn_end; with irqRq=1 no entry on it; next insn_end enters SAVE.
REQ-024 pc=12'o4567, entry, mem_ack after 4 cycles -> mem_addr=0, mem_wdata=12'o4567 held 4 cycles, then pc_load, pc_new=12'o0001, irq_taken, ion=0.
REQ-025 ion_set and ion_clr same cycle -> ion_pend=0, ion=0; subsequent insn_end with irqRq=1 -> no entry.
REQ-026 RESETn low during SAVE -> next cycle IDLE, mem_req=0, busy=0; later mem_ack ignored.
REQ-027 VECTOR=12'o0000 -> save address 12'o7777 (wrap), pc_new=0.
